// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: imem request/ack, IF/ID register, flush and timeout handling
module instruction_fetch_unit #(
    parameter int INSTR_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic [63:0]            PC,
    input  logic                   flush,
    output logic [63:0]            imem_addr,
    output logic                   imem_req,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   ID_ready,
    output logic [INSTR_WIDTH-1:0] IR,
    output logic [63:0]            IR_PC,
    output logic [63:0]            IR_PC4,
    output logic                   IR_valid,
    output logic                   pc_advance,
    output logic                   fetch_fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RELOAD,
        S_DISCARD,
        S_DRAIN,
        S_FAULT
    } state_t;

    state_t                 state_q;
    logic [63:0]            addr_q;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [63:0]            ir_pc_q;
    logic [63:0]            ir_pc4_q;
    logic                   ir_valid_q;
    logic                   req_q;
    logic                   fault_q;
    logic [CW-1:0]          cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_pc4_q   <= '0;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_FETCH;
                        addr_q  <= PC;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack && !flush) begin
                        ir_q       <= imem_data;
                        ir_pc_q    <= addr_q;
                        ir_pc4_q   <= addr_q + 64'd4;
                        ir_valid_q <= 1'b1;
                        req_q      <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_DRAIN;
                    end else if (imem_ack) begin
                        // PC carries the branch target only from the next cycle, so wait one.
                        ir_valid_q <= 1'b0;
                        req_q      <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_RELOAD;
                    end else if (flush) begin
                        ir_valid_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_DISCARD;
                    end else if (cnt_q == CNT_LAST) begin
                        fault_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RELOAD: begin
                    addr_q  <= PC;
                    req_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_FETCH;
                end
                S_DISCARD: begin
                    ir_valid_q <= 1'b0;
                    if (imem_ack) begin
                        addr_q  <= PC;
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end else if (cnt_q == CNT_LAST) begin
                        fault_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (flush || ID_ready) begin
                        ir_valid_q <= 1'b0;
                        addr_q     <= PC;
                        req_q      <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_FETCH;
                    end
                end
                S_FAULT: begin
                    ir_valid_q <= 1'b0;
                    req_q      <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = addr_q;
    assign imem_req    = req_q;
    assign IR          = ir_q;
    assign IR_PC       = ir_pc_q;
    assign IR_PC4      = ir_pc4_q;
    assign IR_valid    = ir_valid_q;
    assign fetch_fault = fault_q;
    assign pc_advance  = (state_q == S_FETCH) & imem_ack & ~flush;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed bench with a flag-based fetch model checked every cycle
module tb_instruction_fetch_unit;

    localparam int TO = 8;

    logic        clock;
    logic        reset;
    logic        run;
    logic [63:0] PC;
    logic        flush;
    logic [63:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        ID_ready;
    logic [31:0] IR;
    logic [63:0] IR_PC;
    logic [63:0] IR_PC4;
    logic        IR_valid;
    logic        pc_advance;
    logic        fetch_fault;

    int n_chk;
    int n_fail;
    int nadv;
    logic adv;

    instruction_fetch_unit #(.INSTR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .run(run), .PC(PC), .flush(flush),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_data(imem_data), .ID_ready(ID_ready), .IR(IR), .IR_PC(IR_PC),
        .IR_PC4(IR_PC4), .IR_valid(IR_valid), .pc_advance(pc_advance),
        .fetch_fault(fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: a request is either outstanding (possibly stale), pending a reload,
    // or an instruction is being held; a fault freezes everything.
    bit          m_on, m_out, m_stale, m_reload, m_hold, m_dead;
    int          m_wait;
    logic [63:0] m_addr, m_irpc, m_irpc4;
    logic [31:0] m_ir;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_on = 0; m_out = 0; m_stale = 0; m_reload = 0; m_hold = 0; m_dead = 0;
            m_wait = 0; m_addr = '0; m_irpc = '0; m_irpc4 = '0; m_ir = '0;
        end else if (m_dead) begin
            m_out = 0;
        end else if (!m_on) begin
            if (run) begin m_on = 1; m_out = 1; m_addr = PC; m_wait = 0; end
        end else if (m_hold) begin
            if (flush || ID_ready) begin m_hold = 0; m_out = 1; m_addr = PC; m_wait = 0; end
        end else if (m_reload) begin
            m_reload = 0; m_out = 1; m_addr = PC; m_wait = 0;
        end else if (m_out) begin
            if (imem_ack) begin
                m_wait = 0;
                if (m_stale) begin
                    m_stale = 0; m_addr = PC;
                end else if (flush) begin
                    m_out = 0; m_reload = 1;
                end else begin
                    m_out = 0; m_hold = 1;
                    m_ir = imem_data; m_irpc = m_addr; m_irpc4 = m_addr + 64'd4;
                end
            end else if (flush && !m_stale) begin
                m_stale = 1; m_wait = 0;
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == TO) begin m_dead = 1; m_out = 0; m_stale = 0; end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        chk("m_req", 64'(imem_req), 64'(m_out));
        chk("m_fault", 64'(fetch_fault), 64'(m_dead));
        chk("m_irv", 64'(IR_valid), 64'(m_hold));
        chk("m_adv", 64'(pc_advance), 64'(m_out && !m_stale && imem_ack && !flush));
        if (m_out) chk("m_addr", imem_addr, m_addr);
        if (m_hold) begin
            chk("m_ir", 64'(IR), 64'(m_ir));
            chk("m_irpc", IR_PC, m_irpc);
            chk("m_irpc4", IR_PC4, m_irpc4);
        end
    endtask

    // The bench acts as the PC register: it steps by 4 on each pc_advance edge.
    task automatic tick();
        @(negedge clock);
        model_compare();
        adv = pc_advance;
        @(posedge clock);
        #1;
        if (adv) PC = PC + 64'd4;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; nadv = 0;
        reset = 1; run = 0; flush = 0; imem_ack = 0; imem_data = '0; ID_ready = 0; PC = '0;
        tick(); tick();
        chk("rst_ir", 64'(IR), 64'h0);
        chk("rst_irpc", IR_PC, 64'h0);
        chk("rst_irpc4", IR_PC4, 64'h0);
        chk("rst_irv", 64'(IR_valid), 64'd0);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        chk("rst_addr", imem_addr, 64'h0);
        reset = 0; tick();
        chk("idle_req", 64'(imem_req), 64'd0);

        PC = 64'h100; run = 1; tick();
        imem_ack = 1; imem_data = 32'h8B020020; ID_ready = 1; #1;
        chk("f1_addr", imem_addr, 64'h100);
        chk("f1_adv", 64'(pc_advance), 64'd1);
        tick();
        imem_ack = 0; ID_ready = 0; #1;
        chk("f1_ir", 64'(IR), 64'h8B020020);
        chk("f1_irpc", IR_PC, 64'h100);
        chk("f1_irpc4", IR_PC4, 64'h104);
        chk("f1_irv", 64'(IR_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ir", 64'(IR), 64'h8B020020);
            chk("bp_irpc", IR_PC, 64'h100);
            chk("bp_irv", 64'(IR_valid), 64'd1);
            chk("bp_req", 64'(imem_req), 64'd0);
        end
        ID_ready = 1; tick();
        ID_ready = 0; #1;
        chk("bp_next_addr", imem_addr, 64'h104);
        chk("bp_next_req", 64'(imem_req), 64'd1);

        imem_ack = 1; imem_data = 32'h11111111; ID_ready = 1; tick();
        imem_ack = 0; PC = 64'h200; tick();
        ID_ready = 0; #1;
        chk("fw_addr", imem_addr, 64'h200);
        tick();
        flush = 1; tick();
        flush = 0; PC = 64'h400; #1;
        chk("fw_req_held", 64'(imem_req), 64'd1);
        chk("fw_addr_held", imem_addr, 64'h200);
        chk("fw_irv", 64'(IR_valid), 64'd0);
        tick();
        imem_ack = 1; imem_data = 32'h0000DEAD; #1;
        chk("fw_stale_adv", 64'(pc_advance), 64'd0);
        tick();
        imem_ack = 0; #1;
        chk("fw_new_addr", imem_addr, 64'h400);
        chk("fw_irv2", 64'(IR_valid), 64'd0);

        imem_ack = 1; flush = 1; imem_data = 32'h00000BAD; #1;
        chk("fa_adv", 64'(pc_advance), 64'd0);
        tick();
        imem_ack = 0; flush = 0; PC = 64'h800; #1;
        chk("fa_irv", 64'(IR_valid), 64'd0);
        tick();
        chk("fa_addr", imem_addr, 64'h800);
        chk("fa_req", 64'(imem_req), 64'd1);

        imem_ack = 1; imem_data = 32'h12345678; ID_ready = 1; tick();
        imem_ack = 0; PC = 64'hFFFF_FFFF_FFFF_FFFC; tick();
        ID_ready = 0; imem_ack = 1; imem_data = 32'hCAFEF00D; #1;
        chk("wr_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        imem_ack = 0; #1;
        chk("wr_ir", 64'(IR), 64'hCAFEF00D);
        chk("wr_irpc", IR_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_irpc4", IR_PC4, 64'h0);

        PC = 64'h900; flush = 1; tick();
        flush = 0; #1;
        chk("dr_flush_addr", imem_addr, 64'h900);
        chk("dr_flush_irv", 64'(IR_valid), 64'd0);

        for (int i = 0; i < TO; i++) begin
            chk("to_req", 64'(imem_req), 64'd1);
            tick();
        end
        chk("to_fault", 64'(fetch_fault), 64'd1);
        chk("to_req_off", 64'(imem_req), 64'd0);
        flush = 1; imem_ack = 1; tick(); tick();
        flush = 0; imem_ack = 0;
        chk("to_absorb", 64'(fetch_fault), 64'd1);
        chk("to_irv", 64'(IR_valid), 64'd0);
        reset = 1; #1;
        chk("to_async_clr", 64'(fetch_fault), 64'd0);
        tick();
        reset = 0; run = 0; tick(); tick();
        chk("run_low_req", 64'(imem_req), 64'd0);

        run = 1; PC = 64'h40; tick();
        flush = 1; tick();
        flush = 0; tick(); tick();
        chk("dis_req", 64'(imem_req), 64'd1);
        reset = 1; #1;
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        tick();
        reset = 0; tick();

        ID_ready = 1;
        for (int i = 0; i < 8; i++) begin
            imem_ack = imem_req; imem_data = 32'(i); #1;
            if (pc_advance) nadv++;
            tick();
        end
        imem_ack = 0;
        chk("thru_adv", 64'(nadv), 64'd4);

        flush = 1; tick();
        flush = 0;
        for (int i = 0; i < TO; i++) tick();
        chk("dis_to_fault", 64'(fetch_fault), 64'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the current PC and issues a held request/acknowledge read to instruction memory.
- Captures the returned word into a one-entry IF/ID register together with its PC and PC+4.
- Emits a one-cycle pc_advance strobe that control uses to gate PC loading. It also handles branch flushes, discards stale responses and detects memory timeouts.

Parameters:
- INSTR_WIDTH, 32, width of instruction word.
- TIMEOUT_CYCLES, 255, maximum request cycles without imem_ack before a fault is declared.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; permits leaving IDLE.
- PC  input  64  current program counter value.
- flush  input  1  branch/redirect this cycle; PC holds the target from the next cycle.
- imem_addr  output  64  fetch address; stable while imem_req=1.
- imem_req  output  1  read request, held until acknowledged.
- imem_ack  input  1  single-cycle; imem_data is valid in the same cycle.
- imem_data  input  INSTR_WIDTH  instruction word.
- ID_ready  input  1  decode consumes IR this cycle when IR_valid=1.
- IR  output  INSTR_WIDTH  fetched instruction.
- IR_PC  output  64  address of IR.
- IR_PC4  output  64  IR_PC+4.
- IR_valid  output  1  IR holds a live instruction.
- pc_advance  output  1  combinational; PC may load PC+4 at this edge.
- fetch_fault  output  1  sticky timeout flag.

Behaviour:
- Reset (async): state=IDLE; all registers cleared (addr_q, IR, IR_PC, IR_PC4, timeout counter); IR_valid=0; fetch_fault=0; imem_req=0.
- imem_addr = addr_q. addr_q is loaded with PC on every transition into FETCH.
- imem_req = 1 in FETCH and DISCARD; 0 otherwise.
- pc_advance = (state==FETCH) & imem_ack & ~flush. No other source.
- IDLE:
  - run=1 -> FETCH, loading addr_q<=PC.
- FETCH:
  - imem_ack & ~flush:
    - IR<=imem_data; IR_PC<=addr_q; IR_PC4<=addr_q+4 (64-bit, wraps modulo 2^64).
    - IR_valid<=1; -> DRAIN.
  - imem_ack & flush: data dropped; IR_valid<=0; -> FETCH, addr_q<=PC on the next edge. Stay one cycle in a reload substate, or equivalently re-enter FETCH with addr_q loaded at the edge after flush.
  - ~imem_ack & flush: IR_valid<=0; -> DISCARD. Request remains held with the old address.
  - no ack: counter++.
- DISCARD:
  - Wait for imem_ack; drop its data.
  - On ack -> FETCH, addr_q<=PC (the branch target).
  - flush here is ignored beyond keeping IR_valid=0.
- DRAIN:
  - flush -> IR_valid<=0; -> FETCH, addr_q<=PC.
  - else if ID_ready -> IR_valid<=0; -> FETCH, addr_q<=PC. PC already updated by the pc_advance edge.
  - else hold IR and all IR_* outputs stable.
- Timeout:
  - Counter clears on entry to FETCH/DISCARD and on every ack.
  - In FETCH or DISCARD, when the counter reaches TIMEOUT_CYCLES without ack: fetch_fault<=1 -> FAULT.
- FAULT:
  - imem_req=0, IR_valid=0; absorbing until reset. run, flush and ack are ignored.
- Throughput: a zero-wait memory with ID_ready=1 yields one instruction per 2 cycles (FETCH, DRAIN).
- run deassertion: takes effect only in IDLE. An in-flight fetch always completes.
- Reset mid-request: request drops immediately; memory must tolerate abandonment.

Test Plan:
- Reset, run=1, PC=0x100, ack in first FETCH cycle with data 0x8B020020, ID_ready=1 -> imem_addr=0x100, pc_advance=1 in that cycle; next cycle IR=0x8B020020, IR_PC=0x100, IR_PC4=0x104, IR_valid=1.
- Back-pressure: ID_ready=0 for 5 cycles after capture -> IR/IR_PC constant, IR_valid=1, imem_req=0; ID_ready=1 -> next cycle FETCH with imem_addr=0x104.
- Flush during wait: FETCH at 0x200, flush at cycle 2, PC becomes 0x400, ack arrives at cycle 4 with 0xDEAD -> no pc_advance, IR_valid stays 0, next request at 0x400.
- Flush coincident with ack -> data dropped, pc_advance=0, next imem_addr equals the new PC.
- Timeout: TIMEOUT_CYCLES=8, never ack -> fetch_fault=1 after 8 request cycles, imem_req=0 thereafter; async reset clears fetch_fault immediately.
- Wrap: PC=0xFFFFFFFFFFFFFFFC fetched -> IR_PC4=0x0.
